// File: rtl/core_msg_arbiter_pkg.sv
// Shared defaults and message field layout for the core message arbiter.
// Messages carry LEN/PORT/SLOT/ADDR/ERR fields packed into 64 bits.
package core_msg_arbiter_pkg;

    localparam int DEF_CORE_COUNT = 8;
    localparam int DEF_MSG_WIDTH  = 64;

    localparam int LEN_LSB   = 0;
    localparam int LEN_WIDTH = 16;
    localparam int PORT_LSB   = 16;
    localparam int PORT_WIDTH = 8;
    localparam int SLOT_LSB   = 24;
    localparam int SLOT_WIDTH = 8;
    localparam int ADDR_LSB   = 32;
    localparam int ADDR_WIDTH = 16;
    localparam int ERR_LSB   = 48;
    localparam int ERR_WIDTH = 16;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/core_msg_arbiter_rr_arbiter.sv
// Round-robin grant: the first requester at or after ptr (wrapping) wins.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_oh,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);

    int cand;

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!grant_any && req[cand]) begin
                grant_any      = 1'b1;
                grant_oh[cand] = 1'b1;
                grant_idx      = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/core_msg_arbiter.sv
// Arbitrates per-core messages into a one-entry output register toward the DMA
// controller, with an enable mask, saturating per-core grant counters and error flagging.
module core_msg_arbiter
    import core_msg_arbiter_pkg::*;
#(
    parameter int CORE_COUNT    = DEF_CORE_COUNT,
    parameter int CORE_NO_WIDTH = $clog2(CORE_COUNT),
    parameter int MSG_WIDTH     = DEF_MSG_WIDTH,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CORE_COUNT*MSG_WIDTH-1:0] s_msg_data,
    input  logic [CORE_COUNT-1:0]           s_msg_valid,
    output logic [CORE_COUNT-1:0]           s_msg_ready,
    output logic [MSG_WIDTH-1:0]            m_msg_data,
    output logic [CORE_NO_WIDTH-1:0]        m_msg_core_no,
    output logic                            m_msg_valid,
    input  logic                            m_msg_ready,
    input  logic [CORE_COUNT-1:0]           core_mask,
    input  logic                            core_mask_valid,
    input  logic [CORE_NO_WIDTH-1:0]        stat_rd_addr,
    input  logic                            stat_rd_valid,
    output logic [CNT_WIDTH-1:0]            stat_data,
    output logic                            stat_valid,
    output logic                            err,
    output logic [CORE_NO_WIDTH-1:0]        err_core
);

    localparam logic [CORE_NO_WIDTH-1:0] LAST_CORE = CORE_NO_WIDTH'(CORE_COUNT - 1);

    out_state_e                 state_q, state_d;
    logic [MSG_WIDTH-1:0]       data_q, data_d;
    logic [CORE_NO_WIDTH-1:0]   core_no_q, core_no_d;
    logic [CORE_NO_WIDTH-1:0]   ptr_q, ptr_d;
    logic [CORE_COUNT-1:0]      mask_q, mask_d;
    logic [CNT_WIDTH-1:0]       cnt_q [CORE_COUNT];
    logic [CNT_WIDTH-1:0]       cnt_d [CORE_COUNT];
    logic                       stat_valid_q, stat_valid_d;
    logic [CNT_WIDTH-1:0]       stat_data_q, stat_data_d;
    logic                       err_q, err_d;
    logic [CORE_NO_WIDTH-1:0]   err_core_q, err_core_d;

    logic [CORE_COUNT-1:0]      grant_oh;
    logic [CORE_NO_WIDTH-1:0]   grant_idx;
    logic                       grant_any;
    logic                       can_load;
    logic                       grant_fire;
    logic [MSG_WIDTH-1:0]       granted_msg;

    rr_arbiter #(
        .N  (CORE_COUNT),
        .IW (CORE_NO_WIDTH)
    ) u_rr (
        .req       (s_msg_valid & mask_q),
        .ptr       (ptr_q),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // The register frees up either when empty or when its message leaves this cycle.
    assign can_load    = (state_q == OUT_EMPTY) || m_msg_ready;
    assign grant_fire  = can_load && grant_any && !rst;
    assign s_msg_ready = grant_fire ? grant_oh : '0;

    always_comb begin
        granted_msg = '0;
        for (int i = 0; i < CORE_COUNT; i++) begin
            if (grant_oh[i]) begin
                granted_msg = s_msg_data[i*MSG_WIDTH +: MSG_WIDTH];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        core_no_d    = core_no_q;
        ptr_d        = ptr_q;
        mask_d       = core_mask_valid ? core_mask : mask_q;
        cnt_d        = cnt_q;
        stat_valid_d = stat_rd_valid;
        stat_data_d  = stat_data_q;
        err_d        = 1'b0;
        err_core_d   = err_core_q;

        if (grant_fire) begin
            state_d   = OUT_FULL;
            data_d    = granted_msg;
            core_no_d = grant_idx;
            ptr_d     = (grant_idx == LAST_CORE) ? '0 : grant_idx + CORE_NO_WIDTH'(1);
            if (cnt_q[grant_idx] != '1) begin
                cnt_d[grant_idx] = cnt_q[grant_idx] + CNT_WIDTH'(1);
            end
            if (granted_msg[ERR_LSB +: ERR_WIDTH] != '0) begin
                err_d      = 1'b1;
                err_core_d = grant_idx;
            end
        end else if (can_load) begin
            state_d = OUT_EMPTY;
        end

        // Reads see cnt_q, so a read racing an increment returns the old count.
        if (stat_rd_valid) begin
            stat_data_d = '0;
            for (int i = 0; i < CORE_COUNT; i++) begin
                if (stat_rd_addr == CORE_NO_WIDTH'(i)) begin
                    stat_data_d = cnt_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= OUT_EMPTY;
            data_q       <= '0;
            core_no_q    <= '0;
            ptr_q        <= '0;
            mask_q       <= '1;
            // NOTE: the counters are a small flop array, not RAM, so clearing them all in reset is cheap and required.
            for (int i = 0; i < CORE_COUNT; i++) begin
                cnt_q[i] <= '0;
            end
            stat_valid_q <= 1'b0;
            stat_data_q  <= '0;
            err_q        <= 1'b0;
            err_core_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples its _d value from before the edge.
            state_q      <= state_d;
            data_q       <= data_d;
            core_no_q    <= core_no_d;
            ptr_q        <= ptr_d;
            mask_q       <= mask_d;
            cnt_q        <= cnt_d;
            stat_valid_q <= stat_valid_d;
            stat_data_q  <= stat_data_d;
            err_q        <= err_d;
            err_core_q   <= err_core_d;
        end
    end

    assign m_msg_valid   = (state_q == OUT_FULL);
    assign m_msg_data    = data_q;
    assign m_msg_core_no = core_no_q;
    assign stat_valid    = stat_valid_q;
    assign stat_data     = stat_data_q;
    assign err           = err_q;
    assign err_core      = err_core_q;

endmodule

// File: doc/core_msg_arbiter.md
CORE_MSG_ARBITER -- requirements
Module: core_msg_arbiter

Interface
REQ-001 Parameter CORE_COUNT, default 8, number of requesting cores.
REQ-002 Parameter CORE_NO_WIDTH, default $clog2(CORE_COUNT), core index width.
REQ-003 Parameter MSG_WIDTH, default 64, core message width.
REQ-004 Parameter CNT_WIDTH, default 16, per-core message counter width.
REQ-005 Port clk, input, 1, the single clock for all logic.
REQ-006 Port rst, input, 1, reset, asynchronous and active-high.
REQ-007 Port s_msg_data, input, CORE_COUNT*MSG_WIDTH, flattened per-core messages, core i at bits [i*MSG_WIDTH +: MSG_WIDTH].
REQ-008 Port s_msg_valid, input, CORE_COUNT, per-core message valid.
REQ-009 Port s_msg_ready, output, CORE_COUNT, per-core accept strobe, at most one bit high.
REQ-010 Port m_msg_data, output, MSG_WIDTH, arbitrated message toward the DMA controller.
REQ-011 Port m_msg_core_no, output, CORE_NO_WIDTH, source core of m_msg_data.
REQ-012 Port m_msg_valid, output, 1, output message valid.
REQ-013 Port m_msg_ready, input, 1, downstream accept.
REQ-014 Ports core_mask (input, CORE_COUNT) and core_mask_valid (input, 1), load the enable mask; bit=1 enables the core.
REQ-015 Ports stat_rd_addr (input, CORE_NO_WIDTH) and stat_rd_valid (input, 1), counter read request.
REQ-016 Ports stat_data (output, CNT_WIDTH) and stat_valid (output, 1), counter read response.
REQ-017 Ports err (output, 1) and err_core (output, CORE_NO_WIDTH), error pulse and offending core.

Function
REQ-018 Output stage is a one-entry register with states EMPTY (m_msg_valid=0) and FULL (m_msg_valid=1).
REQ-019 Output stage loads when it is EMPTY or when m_msg_valid && m_msg_ready (back-to-back, one message per cycle).
REQ-020 Transitions: FULL->EMPTY on a handshake with no grant; EMPTY->FULL on a grant; FULL->FULL on a handshake with a grant or on a stall.
REQ-021 Eligible set = s_msg_valid & mask_r; a grant occurs only when the output stage can load and the eligible set is non-zero.
REQ-022 Arbitration is round-robin: search starts at ptr, wraps from CORE_COUNT-1 to 0, and the first eligible core wins.
REQ-023 On a grant, ptr <= (granted index + 1) mod CORE_COUNT; with no grant, ptr holds.
REQ-024 s_msg_ready[g] is combinational, high only in the cycle core g's message is captured.
REQ-025 Latency from grant to m_msg_valid is 1 cycle.
REQ-026 While stalled (m_msg_valid=1, m_msg_ready=0), m_msg_data and m_msg_core_no are held stable and all s_msg_ready bits are 0.
REQ-027 On core_mask_valid, mask_r <= core_mask, effective for the next cycle's arbitration.
REQ-028 A masked core gets no grant; a message from it already captured in the output stage is still delivered.
REQ-029 Per-core counter increments on each grant and saturates at all-ones without wrapping.
REQ-030 On stat_rd_valid, stat_data is the counter at stat_rd_addr and stat_valid=1 on the next cycle.
REQ-031 A counter read in the same cycle as that counter's increment returns the pre-increment value.
REQ-032 stat_rd_addr >= CORE_COUNT returns stat_data=0 with stat_valid=1.
REQ-033 If a granted message has bits [63:48] != 0, err pulses for 1 cycle on the next cycle with err_core equal to the granted core; the message is still forwarded.
REQ-034 err_core holds its last value when err=0.

Reset
REQ-035 On rst: m_msg_valid=0, m_msg_data=0, m_msg_core_no=0, s_msg_ready=0, stat_valid=0, stat_data=0, err=0, err_core=0, ptr=0, all counters=0, mask_r all-ones.
REQ-036 Reset asserted mid-operation discards any held message; no handshake completes in the reset cycle.

Structure
REQ-037 A shared package holds the CORE_COUNT and MSG_WIDTH defaults and the message field offsets: LEN [15:0], PORT [23:16], SLOT [31:24], ADDR [47:32], ERR [63:48].
REQ-038 Round-robin grant logic is one sub-module, rr_arbiter (inputs: request vector, ptr; outputs: one-hot grant, grant index, any-grant flag).

Verification
REQ-039 Cores 0, 3 and 5 valid continuously, m_msg_ready=1 -> m_msg_core_no sequence 0,3,5,0,3,5; one message per cycle.
REQ-040 m_msg_ready=0 for 4 cycles with core 2 data 0x...1234 held -> data stable, s_msg_ready=0; after release the next core is granted.
REQ-041 core_mask=8'hFE with core 0 valid only -> no grant; restoring the mask -> grant 1 cycle later.
REQ-042 200 messages from core 7, then stat_rd_addr=7 -> stat_data=200 one cycle later; force counter to 16'hFFFF, one more grant -> stays 16'hFFFF.
REQ-043 Core 4 message with bits [63:48]=16'h0001 -> err=1 for 1 cycle, err_core=4; the message still appears on m_msg_data.
REQ-044 rst asserted while FULL -> m_msg_valid=0 immediately, and after release ptr=0, so core 0 wins a tie with core 1.
